// File: rtl/conv_pkg.sv
// Shared definitions for the CONV datapath pooling stage: data width default,
// memory bank select constants and the pooling FSM state encoding.
package conv_pkg;

  localparam int CONV_DATA_W = 20;

  // Bank numbering: layer-0 (convolution output) banks start at 1,
  // layer-1 (pooled output) banks follow immediately after them.
  localparam logic [2:0] CSEL_L0_BASE = 3'd1;

  function automatic logic [2:0] csel_l1_base(input int num_ch);
    return 3'(int'(CSEL_L0_BASE) + num_ch);
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_RD3  = 3'd4,
    ST_LAST = 3'd5,
    ST_WR   = 3'd6
  } pool_state_t;

endpackage

// File: rtl/pool_engine_if.sv
// Memory-side bus of the pooling engine: start handshake, layer-0 read port,
// layer-1 write port, bank select and the FSM state for observation.
interface pool_engine_if #(
  parameter int DATA_W   = conv_pkg::CONV_DATA_W,
  parameter int LOG_SIDE = 6
);
  import conv_pkg::*;

  // Start handshake: ready is a request sampled only while the engine is idle;
  // busy stays high from the accepting edge until the edge closing the last
  // write, and ready has no effect while busy is high.
  logic                    ready;
  logic                    mode;
  logic                    busy;
  logic                    crd;
  logic [2*LOG_SIDE-1:0]   caddr_rd;
  logic [DATA_W-1:0]       cdata_rd;
  logic                    cwr;
  logic [2*LOG_SIDE-3:0]   caddr_wr;
  logic [DATA_W-1:0]       cdata_wr;
  logic [2:0]              csel;
  pool_state_t             dbg_state;

  modport slave (
    input  ready, mode, cdata_rd,
    output busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel, dbg_state
  );

  modport master (
    output ready, mode, cdata_rd,
    input  busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel, dbg_state
  );

endinterface

// File: rtl/pool_reduce.sv
// Combinational 2x2 window reduction: signed max, plus floor average when
// built with POOL_AVG_EN.
module pool_reduce #(
  parameter int DATA_W = conv_pkg::CONV_DATA_W
) (
  input  logic signed [DATA_W-1:0] p0,
  input  logic signed [DATA_W-1:0] p1,
  input  logic signed [DATA_W-1:0] p2,
  input  logic signed [DATA_W-1:0] p3,
`ifdef POOL_AVG_EN
  input  logic                     mode,
`endif
  output logic signed [DATA_W-1:0] res
);

  logic signed [DATA_W-1:0] m01;
  logic signed [DATA_W-1:0] m23;
  logic signed [DATA_W-1:0] mx;

  // Strict compares keep the earlier-read operand on ties.
  always_comb begin
    m01 = (p1 > p0) ? p1 : p0;
    m23 = (p3 > p2) ? p3 : p2;
    mx  = (m23 > m01) ? m23 : m01;
  end

`ifdef POOL_AVG_EN
  logic signed [DATA_W+1:0] sum;
  logic signed [DATA_W+1:0] avg;

  always_comb begin
    sum = {{2{p0[DATA_W-1]}}, p0} + {{2{p1[DATA_W-1]}}, p1}
        + {{2{p2[DATA_W-1]}}, p2} + {{2{p3[DATA_W-1]}}, p3};
    avg = sum >>> 2;
    res = mode ? avg[DATA_W-1:0] : mx;
  end
`else
  always_comb begin
    res = mx;
  end
`endif

endmodule

// File: rtl/pool_engine.sv
// 2x2 / stride-2 pooling engine: reads layer-0 windows, writes pooled layer-1.
// Define POOL_AVG_EN to include the average datapath selected by mode=1.
module pool_engine
  import conv_pkg::*;
#(
  parameter int DATA_W   = CONV_DATA_W,
  parameter int LOG_SIDE = 6,
  parameter int NUM_CH   = 1
) (
  input logic          clk,
  input logic          reset,
  pool_engine_if.slave bus
);

  localparam int          HW           = LOG_SIDE - 1;
  localparam logic [HW-1:0] LAST_RC    = '1;
  localparam logic [1:0]  LAST_K       = 2'(NUM_CH - 1);
  localparam logic [2:0]  CSEL_L1_BASE = csel_l1_base(NUM_CH);

  pool_state_t state_q, state_d;
  logic [HW-1:0]         r_q, r_d;
  logic [HW-1:0]         c_q, c_d;
  logic [1:0]            k_q, k_d;
  logic [DATA_W-1:0]     pix0_q, pix0_d;
  logic [DATA_W-1:0]     pix1_q, pix1_d;
  logic [DATA_W-1:0]     pix2_q, pix2_d;
  logic                  busy_q, busy_d;
  logic                  crd_q, crd_d;
  logic [2*LOG_SIDE-1:0] caddr_rd_q, caddr_rd_d;
  logic                  cwr_q, cwr_d;
  logic [2*LOG_SIDE-3:0] caddr_wr_q, caddr_wr_d;
  logic [DATA_W-1:0]     cdata_wr_q, cdata_wr_d;
  logic [2:0]            csel_q, csel_d;
  logic                  last_win;
  logic                  rd_phase;
  logic [1:0]            rd_sel;
  logic signed [DATA_W-1:0] reduce_res;

`ifdef POOL_AVG_EN
  logic mode_q, mode_d;
`else
  logic unused_mode;
  assign unused_mode = bus.mode;
`endif

  // The fourth pixel is consumed straight off the read bus in LAST.
  pool_reduce #(.DATA_W(DATA_W)) u_reduce (
    .p0  (pix0_q),
    .p1  (pix1_q),
    .p2  (pix2_q),
    .p3  (bus.cdata_rd),
`ifdef POOL_AVG_EN
    .mode(mode_q),
`endif
    .res (reduce_res)
  );

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    k_d      = k_q;
    pix0_d   = pix0_q;
    pix1_d   = pix1_q;
    pix2_d   = pix2_q;
`ifdef POOL_AVG_EN
    mode_d   = mode_q;
`endif
    last_win = (r_q == LAST_RC) && (c_q == LAST_RC) && (k_q == LAST_K);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.ready) begin
          state_d = ST_RD0;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
`ifdef POOL_AVG_EN
          mode_d  = bus.mode;
`endif
        end
      end
      ST_RD0: state_d = ST_RD1;
      ST_RD1: begin
        state_d = ST_RD2;
        pix0_d  = bus.cdata_rd;
      end
      ST_RD2: begin
        state_d = ST_RD3;
        pix1_d  = bus.cdata_rd;
      end
      ST_RD3: begin
        state_d = ST_LAST;
        pix2_d  = bus.cdata_rd;
      end
      ST_LAST: state_d = ST_WR;
      ST_WR: begin
        if (last_win) begin
          state_d = ST_IDLE;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
        end else begin
          // Raster order: column wraps into row, row wraps into channel.
          state_d = ST_RD0;
          c_d     = c_q + 1'b1;
          if (c_q == LAST_RC) begin
            r_d = r_q + 1'b1;
            if (r_q == LAST_RC) k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    rd_phase = (state_d == ST_RD0) || (state_d == ST_RD1) ||
               (state_d == ST_RD2) || (state_d == ST_RD3);
    rd_sel   = 2'b00;
    unique case (state_d)
      ST_RD1:  rd_sel = 2'b01;
      ST_RD2:  rd_sel = 2'b10;
      ST_RD3:  rd_sel = 2'b11;
      default: rd_sel = 2'b00;
    endcase

    busy_d     = (state_d != ST_IDLE);
    crd_d      = rd_phase;
    cwr_d      = (state_d == ST_WR);
    caddr_rd_d = rd_phase ? {r_d, rd_sel[1], c_d, rd_sel[0]} : caddr_rd_q;
    caddr_wr_d = (state_d == ST_WR) ? {r_d, c_d} : caddr_wr_q;
    cdata_wr_d = (state_q == ST_LAST) ? reduce_res : cdata_wr_q;

    if (rd_phase)
      csel_d = CSEL_L0_BASE + {1'b0, k_d};
    else if ((state_d == ST_LAST) || (state_d == ST_WR))
      csel_d = CSEL_L1_BASE + {1'b0, k_d};
    else
      csel_d = 3'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      r_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      pix0_q     <= '0;
      pix1_q     <= '0;
      pix2_q     <= '0;
      busy_q     <= 1'b0;
      crd_q      <= 1'b0;
      caddr_rd_q <= '0;
      cwr_q      <= 1'b0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
      csel_q     <= 3'd0;
`ifdef POOL_AVG_EN
      mode_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      k_q        <= k_d;
      pix0_q     <= pix0_d;
      pix1_q     <= pix1_d;
      pix2_q     <= pix2_d;
      busy_q     <= busy_d;
      crd_q      <= crd_d;
      caddr_rd_q <= caddr_rd_d;
      cwr_q      <= cwr_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
      csel_q     <= csel_d;
`ifdef POOL_AVG_EN
      mode_q     <= mode_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.crd       = crd_q;
  assign bus.caddr_rd  = caddr_rd_q;
  assign bus.cwr       = cwr_q;
  assign bus.caddr_wr  = caddr_wr_q;
  assign bus.cdata_wr  = cdata_wr_q;
  assign bus.csel      = csel_q;
  assign bus.dbg_state = state_q;

endmodule
